// File: rtl/serv_mtimer.sv
// rtl/serv_mtimer.sv - machine timer (mtime/mtimecmp) on a Wishbone slave port; SERV_MTIMER_64BIT_EN selects 64-bit counters
module serv_mtimer #(
    parameter int PRESCALE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_mtip
);

`ifdef SERV_MTIMER_64BIT_EN
    localparam int W = 64;
`else
    localparam int W = 32;
`endif
    localparam logic [15:0] PMAX = 16'(PRESCALE - 1);

    logic [W-1:0] mtime, mtime_nxt;
    logic [W-1:0] mtimecmp, mtimecmp_nxt;
    logic [15:0]  pcount, pcount_nxt;
    logic [31:0]  rdt_nxt;
    logic         accept;
    logic         wr_en;
    logic         tick;
`ifdef SERV_MTIMER_64BIT_EN
    logic [31:0]  shadow, shadow_nxt;
`endif

    // Replace only the byte lanes enabled by sel
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

    // Next-state: prescaled increment, bus writes overriding it, registered read mux
    always_comb begin
        accept       = i_wb_cyc & i_wb_stb & ~o_wb_ack;
        wr_en        = accept & i_wb_we & (|i_wb_sel);
        tick         = (pcount == PMAX);
        pcount_nxt   = tick ? 16'd0 : pcount + 16'd1;
        mtime_nxt    = tick ? mtime + W'(1) : mtime;
        mtimecmp_nxt = mtimecmp;
        rdt_nxt      = o_wb_rdt;
`ifdef SERV_MTIMER_64BIT_EN
        shadow_nxt   = shadow;
        if (accept) begin
            case (i_wb_adr)
                2'd0: begin
                    rdt_nxt = mtime[31:0];
                    // Latch the upper half so a following hi read is coherent
                    if (!i_wb_we) shadow_nxt = mtime[63:32];
                end
                2'd1:    rdt_nxt = shadow;
                2'd2:    rdt_nxt = mtimecmp[31:0];
                default: rdt_nxt = mtimecmp[63:32];
            endcase
        end
        if (wr_en) begin
            case (i_wb_adr)
                2'd0: begin
                    mtime_nxt  = {mtime[63:32], merge_bytes(mtime[31:0], i_wb_dat, i_wb_sel)};
                    pcount_nxt = 16'd0;
                end
                2'd1: begin
                    mtime_nxt  = {merge_bytes(mtime[63:32], i_wb_dat, i_wb_sel), mtime[31:0]};
                    pcount_nxt = 16'd0;
                end
                2'd2:    mtimecmp_nxt = {mtimecmp[63:32], merge_bytes(mtimecmp[31:0], i_wb_dat, i_wb_sel)};
                default: mtimecmp_nxt = {merge_bytes(mtimecmp[63:32], i_wb_dat, i_wb_sel), mtimecmp[31:0]};
            endcase
        end
`else
        if (accept) begin
            case (i_wb_adr)
                2'd0:    rdt_nxt = mtime;
                2'd2:    rdt_nxt = mtimecmp;
                default: rdt_nxt = 32'h0;
            endcase
        end
        if (wr_en) begin
            case (i_wb_adr)
                2'd0: begin
                    mtime_nxt  = merge_bytes(mtime, i_wb_dat, i_wb_sel);
                    pcount_nxt = 16'd0;
                end
                2'd2:    mtimecmp_nxt = merge_bytes(mtimecmp, i_wb_dat, i_wb_sel);
                default: ;
            endcase
        end
`endif
    end

    // State registers; the interrupt compares the settled register values
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mtime    <= '0;
            mtimecmp <= '1;
            pcount   <= '0;
            o_mtip   <= 1'b0;
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
`ifdef SERV_MTIMER_64BIT_EN
            shadow   <= '0;
`endif
        end else begin
            mtime    <= mtime_nxt;
            mtimecmp <= mtimecmp_nxt;
            pcount   <= pcount_nxt;
            o_mtip   <= (mtime >= mtimecmp);
            o_wb_ack <= accept;
            o_wb_rdt <= rdt_nxt;
`ifdef SERV_MTIMER_64BIT_EN
            shadow   <= shadow_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_serv_mtimer.sv
// tb/tb_serv_mtimer.sv - self-checking bench for serv_mtimer, PRESCALE=1 and PRESCALE=4 instances on one bus
module tb_serv_mtimer;

`ifdef SERV_MTIMER_64BIT_EN
    localparam int W = 64;
`else
    localparam int W = 32;
`endif
    localparam logic [63:0] MASK = (W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  adr = 2'd0;
    logic [31:0] dat = 32'h0;
    logic [3:0]  sel = 4'h0;
    logic        we  = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [31:0] rdt_a, rdt_b;
    logic        ack_a, ack_b, mtip_a, mtip_b;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    serv_mtimer #(.PRESCALE(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb),
        .o_wb_rdt(rdt_a), .o_wb_ack(ack_a), .o_mtip(mtip_a));

    serv_mtimer #(.PRESCALE(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb),
        .o_wb_rdt(rdt_b), .o_wb_ack(ack_b), .o_mtip(mtip_b));

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model: mtime is a linear function of edge count since the last base event
    logic [63:0] bval [2];
    logic [63:0] pval [2];
    int          bedge [2];
    int          pedge [2];
    logic [31:0] shadow_m [2];
    logic [63:0] cmp_m, cmp_prev;
    int          cmp_edge;

    function automatic int ps(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic logic [63:0] mt_at(input int k, input int e);
        int q;
        logic [63:0] v;
        if (e >= bedge[k]) begin
            q = (e - bedge[k]) / ps(k);
            v = bval[k];
        end else begin
            q = (e - pedge[k]) / ps(k);
            v = pval[k];
        end
        if (q < 0) q = 0;
        return (v + 64'(q)) & MASK;
    endfunction

    function automatic logic [63:0] cmp_at(input int e);
        return (e >= cmp_edge) ? cmp_m : cmp_prev;
    endfunction

    function automatic logic exp_mtip(input int k, input int e);
        return mt_at(k, e - 1) >= cmp_at(e - 1);
    endfunction

    function automatic logic [31:0] merge_b(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset(input int r);
        for (int k = 0; k < 2; k++) begin
            bval[k] = 64'h0; pval[k] = 64'h0; bedge[k] = r; pedge[k] = r; shadow_m[k] = 32'h0;
        end
        cmp_m = MASK; cmp_prev = MASK; cmp_edge = r;
    endtask

    task automatic model_access(input logic [1:0] a, input logic w, input logic [31:0] d,
                                input logic [3:0] s, input int acc,
                                output logic [31:0] e0, output logic [31:0] e1);
        logic [63:0] mt, c, nv;
        logic [31:0] e [2];
        logic        upd;
        c = cmp_at(acc - 1);
        for (int k = 0; k < 2; k++) begin
            mt = mt_at(k, acc - 1);
            e[k] = 32'h0;
            if (!w) begin
                case (a)
                    2'd0: begin e[k] = mt[31:0]; if (W == 64) shadow_m[k] = mt[63:32]; end
                    2'd1: e[k] = (W == 64) ? shadow_m[k] : 32'h0;
                    2'd2: e[k] = c[31:0];
                    default: e[k] = (W == 64) ? c[63:32] : 32'h0;
                endcase
            end else if (s != 4'h0) begin
                nv = mt; upd = 1'b0;
                if (a == 2'd0) begin nv[31:0] = merge_b(mt[31:0], d, s); upd = 1'b1; end
                else if (a == 2'd1 && W == 64) begin nv[63:32] = merge_b(mt[63:32], d, s); upd = 1'b1; end
                if (upd) begin
                    pval[k] = bval[k]; pedge[k] = bedge[k]; bval[k] = nv & MASK; bedge[k] = acc;
                end
            end
        end
        if (w && s != 4'h0 && a[1]) begin
            nv = c;
            if (!a[0]) nv[31:0] = merge_b(c[31:0], d, s);
            else if (W == 64) nv[63:32] = merge_b(c[63:32], d, s);
            cmp_prev = c; cmp_m = nv & MASK; cmp_edge = acc;
        end
        e0 = e[0];
        e1 = e[1];
    endtask

    // Called at #1 after a posedge; returns the accept edge and both read-data words
    task automatic bus(input logic [1:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                       output int acc, output logic [31:0] ra, output logic [31:0] rb);
        logic ok;
        adr = a; we = w; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(posedge clk); #1;
            if (ack_a === 1'b1 && ack_b === 1'b1) ok = 1'b1;
        end
        acc = edge_cnt; ra = rdt_a; rb = rdt_b;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bus_ack_timeout adr=%0d ack_a=%b ack_b=%b required=1", a, ack_a, ack_b);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset(edge_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks += 3;
        if (ack_a !== 1'b0 || ack_b !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b/%b required 0", ack_a, ack_b); end
        if (rdt_a !== 32'h0 || rdt_b !== 32'h0) begin n_fail++; $display("FAIL reset_rdt got %h/%h required 0", rdt_a, rdt_b); end
        if (mtip_a !== 1'b0 || mtip_b !== 1'b0) begin n_fail++; $display("FAIL reset_mtip got %b/%b required 0", mtip_a, mtip_b); end
        rst = 1'b0;
        model_reset(edge_cnt);
    endtask

    task automatic test_idle_count();
        int acc, r0;
        logic [31:0] ra, rb, ea, eb;
        do_reset();
        r0 = edge_cnt;
        repeat (10) @(posedge clk);
        #1;
        bus(2'd0, 1'b0, 32'h0, 4'hF, acc, ra, rb);
        model_access(2'd0, 1'b0, 32'h0, 4'hF, acc, ea, eb);
        n_checks += 4;
        if (ra !== ea) begin n_fail++; $display("FAIL idle_mtime_p1 got %0d required %0d", ra, ea); end
        if (rb !== eb) begin n_fail++; $display("FAIL idle_mtime_p4 got %0d required %0d", rb, eb); end
        if (ra !== 32'(acc - 1 - r0)) begin n_fail++; $display("FAIL idle_mtime_abs got %0d required %0d", ra, acc - 1 - r0); end
        if (mtip_a !== 1'b0 || mtip_b !== 1'b0) begin n_fail++; $display("FAIL idle_mtip got %b/%b required 0", mtip_a, mtip_b); end
    endtask

    task automatic test_compare();
        int acc;
        logic [31:0] ra, rb, ea, eb;
        do_reset();
        bus(2'd3, 1'b1, 32'h0, 4'hF, acc, ra, rb);
        model_access(2'd3, 1'b1, 32'h0, 4'hF, acc, ea, eb);
        bus(2'd2, 1'b1, 32'd20, 4'hF, acc, ra, rb);
        model_access(2'd2, 1'b1, 32'd20, 4'hF, acc, ea, eb);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            n_checks += 2;
            if (mtip_a !== exp_mtip(0, edge_cnt)) begin n_fail++; $display("FAIL rise_mtip_p1 edge=%0d got %b required %b", edge_cnt, mtip_a, exp_mtip(0, edge_cnt)); end
            if (mtip_b !== exp_mtip(1, edge_cnt)) begin n_fail++; $display("FAIL rise_mtip_p4 edge=%0d got %b required %b", edge_cnt, mtip_b, exp_mtip(1, edge_cnt)); end
        end
        n_checks++;
        if (mtip_a !== 1'b1 || mtip_b !== 1'b1) begin n_fail++; $display("FAIL mtip_high got %b/%b required 1", mtip_a, mtip_b); end
        bus(2'd2, 1'b1, 32'd1000, 4'hF, acc, ra, rb);
        model_access(2'd2, 1'b1, 32'd1000, 4'hF, acc, ea, eb);
        n_checks++;
        if (mtip_a !== 1'b1) begin n_fail++; $display("FAIL fall_mtip_at_accept got %b required 1", mtip_a); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks += 2;
            if (mtip_a !== exp_mtip(0, edge_cnt)) begin n_fail++; $display("FAIL fall_mtip_p1 edge=%0d got %b required %b", edge_cnt, mtip_a, exp_mtip(0, edge_cnt)); end
            if (mtip_b !== exp_mtip(1, edge_cnt)) begin n_fail++; $display("FAIL fall_mtip_p4 edge=%0d got %b required %b", edge_cnt, mtip_b, exp_mtip(1, edge_cnt)); end
        end
    endtask

    task automatic test_carry();
        int acc;
        logic [31:0] ra, rb, ea, eb, lo_a, lo_b;
        do_reset();
        bus(2'd1, 1'b1, 32'h0, 4'hF, acc, ra, rb);
        model_access(2'd1, 1'b1, 32'h0, 4'hF, acc, ea, eb);
        bus(2'd0, 1'b1, 32'hFFFF_FFFF, 4'hF, acc, ra, rb);
        model_access(2'd0, 1'b1, 32'hFFFF_FFFF, 4'hF, acc, ea, eb);
        bus(2'd0, 1'b0, 32'h0, 4'hF, acc, lo_a, lo_b);
        model_access(2'd0, 1'b0, 32'h0, 4'hF, acc, ea, eb);
        n_checks += 3;
        if (lo_a !== ea) begin n_fail++; $display("FAIL carry_lo_p1 got %h required %h", lo_a, ea); end
        if (lo_b !== eb) begin n_fail++; $display("FAIL carry_lo_p4 got %h required %h", lo_b, eb); end
        if (lo_a !== 32'h0) begin n_fail++; $display("FAIL carry_lo_abs got %h required 00000000", lo_a); end
        repeat (5) @(posedge clk);
        #1;
        bus(2'd1, 1'b0, 32'h0, 4'hF, acc, ra, rb);
        model_access(2'd1, 1'b0, 32'h0, 4'hF, acc, ea, eb);
        n_checks += 4;
        if (ra !== ea) begin n_fail++; $display("FAIL carry_hi_p1 got %h required %h", ra, ea); end
        if (rb !== eb) begin n_fail++; $display("FAIL carry_hi_p4 got %h required %h", rb, eb); end
`ifdef SERV_MTIMER_64BIT_EN
        if (ra !== 32'h1) begin n_fail++; $display("FAIL carry_hi_abs got %h required 00000001", ra); end
        if (rb !== 32'h0) begin n_fail++; $display("FAIL staged_hi_shadow got %h required 00000000", rb); end
`else
        if (ra !== 32'h0) begin n_fail++; $display("FAIL hi_absent_p1 got %h required 00000000", ra); end
        if (rb !== 32'h0) begin n_fail++; $display("FAIL hi_absent_p4 got %h required 00000000", rb); end
`endif
    endtask

    task automatic test_byte_merge();
        int acc;
        logic [31:0] ra, rb, ea, eb;
        do_reset();
        bus(2'd2, 1'b1, 32'h0000_AB00, 4'b0010, acc, ra, rb);
        model_access(2'd2, 1'b1, 32'h0000_AB00, 4'b0010, acc, ea, eb);
        bus(2'd2, 1'b0, 32'h0, 4'hF, acc, ra, rb);
        model_access(2'd2, 1'b0, 32'h0, 4'hF, acc, ea, eb);
        n_checks += 2;
        if (ra !== 32'hFFFF_ABFF || rb !== 32'hFFFF_ABFF) begin n_fail++; $display("FAIL byte_merge got %h/%h required FFFFABFF", ra, rb); end
        if (ra !== ea) begin n_fail++; $display("FAIL byte_merge_model got %h required %h", ra, ea); end
        bus(2'd2, 1'b1, 32'h1234_5678, 4'b0000, acc, ra, rb);
        model_access(2'd2, 1'b1, 32'h1234_5678, 4'b0000, acc, ea, eb);
        bus(2'd2, 1'b0, 32'h0, 4'hF, acc, ra, rb);
        model_access(2'd2, 1'b0, 32'h0, 4'hF, acc, ea, eb);
        n_checks++;
        if (ra !== 32'hFFFF_ABFF || rb !== 32'hFFFF_ABFF) begin n_fail++; $display("FAIL sel0_write got %h/%h required FFFFABFF", ra, rb); end
    endtask

    task automatic test_prescale();
        int acc, wacc;
        logic [31:0] ra, rb, ea, eb;
        do_reset();
        bus(2'd1, 1'b1, 32'h0, 4'hF, acc, ra, rb);
        model_access(2'd1, 1'b1, 32'h0, 4'hF, acc, ea, eb);
        bus(2'd0, 1'b1, 32'd100, 4'hF, wacc, ra, rb);
        model_access(2'd0, 1'b1, 32'd100, 4'hF, wacc, ea, eb);
        for (int i = 0; i < 8; i++) begin
            bus(2'd0, 1'b0, 32'h0, 4'hF, acc, ra, rb);
            model_access(2'd0, 1'b0, 32'h0, 4'hF, acc, ea, eb);
            n_checks += 3;
            if (ra !== ea) begin n_fail++; $display("FAIL prescale_p1 got %0d required %0d", ra, ea); end
            if (rb !== eb) begin n_fail++; $display("FAIL prescale_p4 got %0d required %0d", rb, eb); end
            if ((acc - 1 - wacc) < 4 && rb !== 32'd100) begin n_fail++; $display("FAIL prescale_early got %0d required 100", rb); end
        end
    endtask

    task automatic test_random();
        int acc;
        logic [1:0]  a;
        logic        w;
        logic [31:0] d, ra, rb, ea, eb;
        logic [3:0]  s;
        logic        m0, m1;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            a = 2'($urandom);
            w = 1'($urandom);
            s = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 60)) : $urandom;
            if (a[0] && $urandom_range(0, 1) == 0) d = 32'h0;
            bus(a, w, d, s, acc, ra, rb);
            m0 = exp_mtip(0, acc);
            m1 = exp_mtip(1, acc);
            model_access(a, w, d, s, acc, ea, eb);
            n_checks += 2;
            if (mtip_a !== m0) begin n_fail++; $display("FAIL rand_mtip_p1 i=%0d got %b required %b", i, mtip_a, m0); end
            if (mtip_b !== m1) begin n_fail++; $display("FAIL rand_mtip_p4 i=%0d got %b required %b", i, mtip_b, m1); end
            if (!w) begin
                n_checks += 2;
                if (ra !== ea) begin n_fail++; $display("FAIL rand_rdt_p1 i=%0d adr=%0d got %h required %h", i, a, ra, ea); end
                if (rb !== eb) begin n_fail++; $display("FAIL rand_rdt_p4 i=%0d adr=%0d got %h required %h", i, a, rb, eb); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] c;
        do_reset();
        c = cmp_at(edge_cnt);
        adr = 2'd2; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ack_a !== ((i % 2) == 0) || ack_b !== ((i % 2) == 0)) begin
                n_fail++; $display("FAIL b2b_ack i=%0d got %b/%b required %b", i, ack_a, ack_b, (i % 2) == 0);
            end
            if (ack_a === 1'b1) begin
                n_checks++;
                if (rdt_a !== c[31:0]) begin n_fail++; $display("FAIL b2b_rdt i=%0d got %h required %h", i, rdt_a, c[31:0]); end
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (ack_a !== 1'b1) begin n_fail++; $display("FAIL b2b_ack_pre_reset got %b required 1", ack_a); end
        rst = 1'b1; we = 1'b1; dat = 32'h0000_0005;
        @(posedge clk); #1;
        n_checks++;
        if (ack_a !== 1'b0 || ack_b !== 1'b0) begin n_fail++; $display("FAIL reset_drops_ack got %b/%b required 0", ack_a, ack_b); end
        rst = 1'b0; we = 1'b0; adr = 2'd0;
        model_reset(edge_cnt);
        @(posedge clk); #1;
        n_checks += 2;
        if (ack_a !== 1'b1) begin n_fail++; $display("FAIL post_reset_ack got %b required 1", ack_a); end
        if (rdt_a !== 32'h0 || rdt_b !== 32'h0) begin n_fail++; $display("FAIL post_reset_mtime got %h/%h required 0", rdt_a, rdt_b); end
        adr = 2'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        n_checks++;
        if (rdt_a !== MASK[31:0]) begin n_fail++; $display("FAIL reset_no_write got %h required %h", rdt_a, MASK[31:0]); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_count();
        test_compare();
        test_carry();
        test_byte_merge();
        test_prescale();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
